// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// Start/busy/done handshake; the result is held until the next accepted start.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             d, bor_nxt, last;

  // Single 1-bit full-subtractor cell shared by every bit position.
  assign d       = sh_a[0] ^ sh_b[0] ^ bor;
  assign bor_nxt = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & bor);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      cnt        <= '0;
      bor        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sh_a <= a;
      sh_b <= b;
      bor  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      // Result bits enter from the MSB so bit 0 lands at the LSB after WIDTH steps.
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      res  <= {d, res[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      bor  <= bor_nxt;
      if (last) begin
        diff       <= {d, res[WIDTH-1:1]};
        borrow_out <= bor_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomized self-checking bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op and follow it to its done pulse; optionally pulse start at RUN edges 3 and 5.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input bit glitch);
    logic [7:0] ed;
    logic       eb;
    logic [7:0] held;
    int         cyc;
    ed   = oa - ob;
    eb   = (oa < ob);
    held = diff;
    a = oa; b = ob; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < WIDTH + 4) begin
      check("busy_run", 32'(busy), 32'd1);
      check("diff_hold_run", 32'(diff), 32'(held));
      start = (glitch && (cyc == 2 || cyc == 4)) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(WIDTH));
    check("busy_in_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(borrow_out), 32'(eb));
    tick();
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("diff_hold_idle", 32'(diff), 32'(ed));
    if (glitch) begin
      for (int i = 0; i < 12; i++) begin
        check("glitch_no_done", 32'(done), 32'd0);
        check("glitch_no_busy", 32'(busy), 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    logic [7:0] ra, rb, hold;
    int         gap;
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    #20 reset = 1'b1;
    tick();
    tick();

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h10, 8'h01, 1'b1);

    // Held start: a new op every WIDTH+2 cycles, done after edges 8, 18, 28.
    a = 8'h80; b = 8'h01; start = 1'b1;
    for (int t = 0; t < 32; t++) begin
      tick();
      check("held_done", 32'(done), ((t % 10) == 8) ? 32'd1 : 32'd0);
      if ((t % 10) == 8) begin
        check("held_diff", 32'(diff), 32'h7F);
        check("held_borrow", 32'(borrow_out), 32'd0);
      end
    end
    start = 1'b0;
    repeat (12) tick();

    // Asynchronous reset in the middle of RUN.
    a = 8'h55; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow_out), 32'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    for (int n = 0; n < 256; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 1'b0);
      hold = diff;
      gap  = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_diff_hold", 32'(diff), 32'(hold));
        check("gap_no_done", 32'(done), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
